image_capture: RTL and testbench
================================

# image_capture

Downstream sink for the two-pixel-per-clock RGB stream produced by the image read/processing stage. Each valid beat (HSYNC high) carries an even/odd pixel pair. The block counts columns and rows, reorders the rows bottom-up into BMP order, and packs the pair into one 48-bit BGR word. It drives a simple write port into the frame buffer, then flags completion, short frames and overflow for the top-level testbench and file writer.

## Interface
Parameters:
- WIDTH, 768, pixels per line; must be even.
- HEIGHT, 512, lines per frame.
- ADDR_W, 18, write-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT/2.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  synchronous reset, active-high.
- HSYNC  in  1  beat valid; one pixel pair per high cycle.
- DATA_R0, DATA_G0, DATA_B0  in  8 each  even pixel.
- DATA_R1, DATA_G1, DATA_B1  in  8 each  odd pixel.
- frame_end  in  1  upstream done flag; level or pulse.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  pair address, BMP bottom-up order.
- wr_data  out  48  packed pair.
- frame_done  out  1  frame closed; level.
- err_short  out  1  sticky; frame ended before WIDTH*HEIGHT pixels.
- err_overflow  out  1  sticky; beat received after frame closed.

## Operation
- FSM states: IDLE, CAPTURE, DONE.
- IDLE:
  - First HSYNC beat is written and moves the FSM to CAPTURE.
  - frame_end is ignored.
- CAPTURE: every HSYNC beat writes one pair, then advances col_pair (0..WIDTH/2-1).
  - At wrap, col_pair resets to 0 and row increments.
- Address is generated incrementally, with no multiplier:
  - row_base resets to (HEIGHT-1)*WIDTH/2.
  - row_base decreases by WIDTH/2 at each row wrap.
  - wr_addr = row_base + col_pair.
- Packing, byte-ascending: [7:0]=B0, [15:8]=G0, [23:16]=R0, [31:24]=B1, [39:32]=G1, [47:40]=R1.
- Transitions out of CAPTURE:
  - Beat at row HEIGHT-1, col_pair WIDTH/2-1 → DONE, err_short stays 0.
  - frame_end high without that final beat → DONE, err_short=1.
  - Final beat and frame_end in the same cycle → final beat is written, DONE, err_short=0.
- DONE:
  - frame_done=1 until HRESET.
  - Any HSYNC beat → no write, err_overflow=1.
- HRESET mid-frame: state, counters and outputs go to reset values, and row_base is reloaded; the next beat starts at the top-row base.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, err_short=0, err_overflow=0; state IDLE.
- Write latency is 1 cycle: a beat sampled at edge N appears as wr_en/wr_addr/wr_data valid after edge N.
  - wr_en is high for exactly one cycle per accepted beat.
- frame_done rises in the same cycle as the final beat's wr_en, or one cycle after frame_end is sampled in CAPTURE.
- The block has no backpressure; back-to-back beats are sustained at one pair per clock.
- Gaps in HSYNC produce no writes and hold the counters.

## Configuration
- CAPTURE_GRAYSCALE_EN defined:
  - Each pixel is replaced by gray = (R>>2)+(G>>1)+(B>>2), an 8-bit result that cannot overflow.
  - gray is written to all three channel bytes of that pixel.
  - Latency is unchanged (computed before the output register).
- CAPTURE_GRAYSCALE_EN undefined: colour channels are passed through unchanged.

## Structure
- Shared package image_pkg:
  - FSM state enum.
  - Byte-lane offsets for B/G/R, even/odd.
  - Gray-weight shift constants.
- One natural sub-module: bmp_addr_gen. It owns col_pair, row, row_base and last-beat detect, with inputs advance and clear and outputs addr and last.
- Packing, the FSM and flags stay in image_capture.

## Test plan
- WIDTH=4, HEIGHT=2, 4 consecutive beats → wr_addr 2,3,0,1; frame_done rises with the 4th wr_en; err_short=0.
- Packing: R0=0x11 G0=0x22 B0=0x33 R1=0x44 G1=0x55 B1=0x66 → wr_data=0x445566112233 one cycle later.
- Beats with 1–3 idle cycles between them → wr_en count equals beat count; addresses contiguous as in test 1.
- WIDTH=4, HEIGHT=2:
  - frame_end after 2 beats → frame_done=1, err_short=1.
  - A further beat → no wr_en, err_overflow=1.
- HRESET asserted after 3 beats, then a new frame → first wr_addr=2; all flags 0 until completion.
- With CAPTURE_GRAYSCALE_EN: R=0x80 G=0x80 B=0x80 → each byte 0x80; R=0xFF G=0 B=0 → 0x3F replicated.

Source files
------------

// File: rtl/image_pkg.sv
// Shared types and constants for the image capture sink: FSM state,
// byte-lane positions inside the packed BGR pair word and gray weights.
package image_pkg;

  localparam int PAIR_W = 48;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } cap_state_e;

  // Byte-ascending BGR layout: even pixel in the low half, odd in the high half.
  localparam int B0_LSB = 0;
  localparam int G0_LSB = 8;
  localparam int R0_LSB = 16;
  localparam int B1_LSB = 24;
  localparam int G1_LSB = 32;
  localparam int R1_LSB = 40;

  localparam int GRAY_SH_R = 2;
  localparam int GRAY_SH_G = 1;
  localparam int GRAY_SH_B = 2;

  // Weights sum to 1, so the largest result is 63+127+63 and never wraps.
  function automatic logic [7:0] to_gray(input logic [7:0] r, input logic [7:0] g,
                                         input logic [7:0] b);
    return (r >> GRAY_SH_R) + (g >> GRAY_SH_G) + (b >> GRAY_SH_B);
  endfunction

endpackage

// File: rtl/image_capture_if.sv
// Pixel-pair stream in and frame-buffer write port out of the capture block.
interface image_capture_if #(
  parameter int ADDR_W = 18
);
  import image_pkg::*;

  logic              HSYNC;
  logic [7:0]        DATA_R0, DATA_G0, DATA_B0;
  logic [7:0]        DATA_R1, DATA_G1, DATA_B1;
  logic              frame_end;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [PAIR_W-1:0] wr_data;

  modport master (
    output HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, frame_end,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, frame_end,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/image_capture_bmp_addr_gen.sv
// Bottom-up BMP pair addressing: walks columns of pairs, rows top to bottom,
// and keeps a running row base so no multiplier is needed.
module bmp_addr_gen #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              advance,
  input  logic              clear,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  localparam int PAIRS = WIDTH / 2;
  localparam int COL_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(PAIRS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] TOP_BASE = ADDR_W'((HEIGHT - 1) * PAIRS);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(PAIRS);

  logic [COL_W-1:0]  col_pair;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] row_base;

  always_ff @(posedge clk) begin
    if (clear) begin
      col_pair <= '0;
      row      <= '0;
      row_base <= TOP_BASE;
    end else if (advance) begin
      if (last) begin
        // Reload rather than stepping row_base below zero after the final pair.
        col_pair <= '0;
        row      <= '0;
        row_base <= TOP_BASE;
      end else if (col_pair == COL_LAST) begin
        col_pair <= '0;
        row      <= row + 1'b1;
        row_base <= row_base - ROW_STEP;
      end else begin
        col_pair <= col_pair + 1'b1;
      end
    end
  end

  assign addr = row_base + ADDR_W'(col_pair);
  assign last = (row == ROW_LAST) && (col_pair == COL_LAST);

endmodule

// File: rtl/image_capture.sv
// Frame-buffer sink for a two-pixel-per-clock RGB stream; packs each pair into
// a 48-bit BGR word at its BMP address. Define CAPTURE_GRAYSCALE_EN for gray output.
module image_capture
  import image_pkg::*;
#(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 18
) (
  input  logic            HCLK,
  input  logic            HRESET,
  image_capture_if.slave  bus,
  output logic            frame_done,
  output logic            err_short,
  output logic            err_overflow
);
  cap_state_e        state;
  logic              beat;
  logic              advance;
  logic              last;
  logic [ADDR_W-1:0] addr;
  logic [PAIR_W-1:0] pix_word;

  assign beat    = bus.HSYNC;
  assign advance = beat && (state != DONE);

  bmp_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk     (HCLK),
    .advance (advance),
    .clear   (HRESET),
    .addr    (addr),
    .last    (last)
  );

`ifdef CAPTURE_GRAYSCALE_EN
  logic [7:0] y0, y1;
  assign y0 = to_gray(bus.DATA_R0, bus.DATA_G0, bus.DATA_B0);
  assign y1 = to_gray(bus.DATA_R1, bus.DATA_G1, bus.DATA_B1);

  always_comb begin
    // NOTE: assign a default first so no path through the block infers a latch.
    pix_word               = '0;
    pix_word[B0_LSB +: 8]  = y0;
    pix_word[G0_LSB +: 8]  = y0;
    pix_word[R0_LSB +: 8]  = y0;
    pix_word[B1_LSB +: 8]  = y1;
    pix_word[G1_LSB +: 8]  = y1;
    pix_word[R1_LSB +: 8]  = y1;
  end
`else
  always_comb begin
    // NOTE: assign a default first so no path through the block infers a latch.
    pix_word               = '0;
    pix_word[B0_LSB +: 8]  = bus.DATA_B0;
    pix_word[G0_LSB +: 8]  = bus.DATA_G0;
    pix_word[R0_LSB +: 8]  = bus.DATA_R0;
    pix_word[B1_LSB +: 8]  = bus.DATA_B1;
    pix_word[G1_LSB +: 8]  = bus.DATA_G1;
    pix_word[R1_LSB +: 8]  = bus.DATA_R1;
  end
`endif

  // NOTE: state and outputs use <= so every branch sees the pre-edge values.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state        <= IDLE;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      frame_done   <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (beat) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= addr;
            bus.wr_data <= pix_word;
            state       <= last ? DONE : CAPTURE;
            frame_done  <= last;
          end
        end
        CAPTURE: begin
          if (beat) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= addr;
            bus.wr_data <= pix_word;
          end
          // A final pair closes the frame cleanly even if frame_end arrives with it.
          if (beat && last) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else if (bus.frame_end) begin
            state      <= DONE;
            frame_done <= 1'b1;
            err_short  <= 1'b1;
          end
        end
        DONE: begin
          if (beat) err_overflow <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_capture.sv
// Self-checking bench for image_capture on a 4x2 frame: directed scenarios
// followed by randomized traffic against a pixel-index reference model.
module tb_image_capture;
  localparam int W      = 4;
  localparam int H      = 2;
  localparam int AW     = 2;
  localparam int PAIRS  = W / 2;
  localparam int TOTAL  = W * H / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_done, err_short, err_overflow;

  image_capture_if #(.ADDR_W(AW)) bus ();

  image_capture #(
    .WIDTH  (W),
    .HEIGHT (H),
    .ADDR_W (AW)
  ) dut (
    .HCLK         (clk),
    .HRESET       (rst),
    .bus          (bus),
    .frame_done   (frame_done),
    .err_short    (err_short),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pairs accepted in this frame plus the three flags.
  int m_pairs;
  bit m_done, m_short, m_ovf;
  int n_wr_seen, n_beats_sent;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_gray(input int r, input int g, input int b);
    int v;
    v = r / 4 + g / 2 + b / 4;
    return v[7:0];
  endfunction

  function automatic logic [47:0] m_pack(input logic [7:0] r0, g0, b0, r1, g1, b1);
`ifdef CAPTURE_GRAYSCALE_EN
    logic [7:0] y0, y1;
    y0 = m_gray(r0, g0, b0);
    y1 = m_gray(r1, g1, b1);
    return {y1, y1, y1, y0, y0, y0};
`else
    return {r1, g1, b1, r0, g0, b0};
`endif
  endfunction

  // BMP stores the bottom row first, so pixel row r lands at row H-1-r.
  function automatic int m_addr(input int k);
    return (H - 1 - k / PAIRS) * PAIRS + (k % PAIRS);
  endfunction

  function automatic logic [7:0] rb();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic check_flags(input string tag);
    check({tag, ".frame_done"}, 64'(frame_done), 64'(m_done));
    check({tag, ".err_short"}, 64'(err_short), 64'(m_short));
    check({tag, ".err_overflow"}, 64'(err_overflow), 64'(m_ovf));
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.HSYNC   = 1'b0;
    bus.frame_end = 1'b0;
    @(posedge clk); #1;
    check("rst.wr_en", 64'(bus.wr_en), 64'd0);
    check("rst.wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst.wr_data", 64'(bus.wr_data), 64'd0);
    m_pairs = 0; m_done = 0; m_short = 0; m_ovf = 0;
    check_flags("rst");
    rst = 1'b0;
  endtask

  // One clock of stimulus; outputs are checked #1 after the edge that sampled it.
  task automatic cycle(input bit hs, input bit fe, input logic [7:0] r0, g0, b0, r1, g1, b1);
    bit          exp_wr;
    int          exp_a;
    logic [47:0] exp_d;
    bit          capturing;
    bus.HSYNC   = hs;
    bus.frame_end = fe;
    bus.DATA_R0 = r0; bus.DATA_G0 = g0; bus.DATA_B0 = b0;
    bus.DATA_R1 = r1; bus.DATA_G1 = g1; bus.DATA_B1 = b1;
    exp_wr = 0; exp_a = 0; exp_d = '0;
    capturing = (m_pairs > 0);
    if (!m_done) begin
      if (hs) begin
        exp_wr = 1;
        exp_a  = m_addr(m_pairs);
        exp_d  = m_pack(r0, g0, b0, r1, g1, b1);
        m_pairs++;
        n_beats_sent++;
        if (m_pairs == TOTAL) m_done = 1;
        else if (fe && capturing) begin m_done = 1; m_short = 1; end
      end else if (fe && capturing) begin
        m_done = 1; m_short = 1;
      end
    end else if (hs) begin
      m_ovf = 1;
    end
    @(posedge clk); #1;
    bus.HSYNC = 1'b0;
    bus.frame_end = 1'b0;
    check("wr_en", 64'(bus.wr_en), 64'(exp_wr));
    if (bus.wr_en) n_wr_seen++;
    if (exp_wr) begin
      check("wr_addr", 64'(bus.wr_addr), 64'(exp_a));
      check("wr_data", 64'(bus.wr_data), 64'(exp_d));
    end
    check_flags("flags");
  endtask

  task automatic rand_beat(input bit fe);
    cycle(1'b1, fe, rb(), rb(), rb(), rb(), rb(), rb());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
  endtask

  initial begin
    bus.HSYNC = 1'b0; bus.frame_end = 1'b0;
    bus.DATA_R0 = '0; bus.DATA_G0 = '0; bus.DATA_B0 = '0;
    bus.DATA_R1 = '0; bus.DATA_G1 = '0; bus.DATA_B1 = '0;
    n_wr_seen = 0; n_beats_sent = 0;

    // Full frame back-to-back, first pair carries the packing pattern.
    do_reset();
    idle(2);
    cycle(1'b1, 1'b0, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66);
`ifndef CAPTURE_GRAYSCALE_EN
    check("pack_const", 64'(bus.wr_data), 64'h4455_6611_2233);
`endif
    check("first_addr", 64'(bus.wr_addr), 64'd2);
    rand_beat(1'b0);
    rand_beat(1'b0);
    rand_beat(1'b0);
    check("done_with_last", 64'(frame_done), 64'd1);
    check("last_addr", 64'(bus.wr_addr), 64'd1);
    // Beat after close is dropped and flagged.
    rand_beat(1'b0);
    idle(1);

    // Gapped beats: every beat written once, addresses still contiguous.
    do_reset();
    n_wr_seen = 0; n_beats_sent = 0;
    for (int i = 0; i < TOTAL; i++) begin
      rand_beat(1'b0);
      idle($urandom_range(1, 3));
    end
    check("gap_wr_count", 64'(n_wr_seen), 64'(n_beats_sent));

    // Short frame then overflow.
    do_reset();
    rand_beat(1'b0);
    rand_beat(1'b0);
    cycle(1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    check("short_flag", 64'(err_short), 64'd1);
    rand_beat(1'b0);
    check("ovf_flag", 64'(err_overflow), 64'd1);

    // Mid-frame reset restarts at the top-row base.
    do_reset();
    rand_beat(1'b0); rand_beat(1'b0); rand_beat(1'b0);
    do_reset();
    rand_beat(1'b0);
    check("restart_addr", 64'(bus.wr_addr), 64'd2);
    rand_beat(1'b0); rand_beat(1'b0); rand_beat(1'b0);

    // Final beat coincident with frame_end is a clean close.
    do_reset();
    rand_beat(1'b0); rand_beat(1'b0); rand_beat(1'b0);
    rand_beat(1'b1);
    check("coincident_short", 64'(err_short), 64'd0);

    // frame_end while idle is ignored.
    do_reset();
    cycle(1'b0, 1'b1, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0);
    rand_beat(1'b1);
    check("idle_fe_done", 64'(frame_done), 64'd0);
    idle(1);

`ifdef CAPTURE_GRAYSCALE_EN
    do_reset();
    cycle(1'b1, 1'b0, 8'h80, 8'h80, 8'h80, 8'hFF, 8'h00, 8'h00);
    check("gray_const", 64'(bus.wr_data), 64'h3F3F_3F80_8080);
`endif

    // Randomized traffic with occasional frame_end and mid-frame resets.
    for (int f = 0; f < 40; f++) begin
      do_reset();
      for (int c = 0; c < 14; c++) begin
        if ($urandom_range(0, 29) == 0) do_reset();
        cycle($urandom_range(0, 2) != 0, $urandom_range(0, 11) == 0,
              rb(), rb(), rb(), rb(), rb(), rb());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
